// File: rtl/zxuno_regbus_ctrl.sv
// ZX-Uno register bus controller.
// Decodes the Z80 IOADDR/IODATA port pair into a register select
// (zxuno_addr), a one-cycle write strobe with data, and a read level.
// Bus inputs are registered once, and accesses are decoded from those
// registered copies. Writes commit on the trailing edge of the access.
module zxuno_regbus_ctrl #(
  parameter logic [15:0] IOADDR = 16'hFC3B,
  parameter logic [15:0] IODATA = 16'hFD3B
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] a,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic [7:0]  din,
  output logic [7:0]  zxuno_addr,
  output logic        zxuno_regrd,
  output logic        zxuno_regwr,
  output logic [7:0]  zxuno_wdata,
  output logic [7:0]  dout,
  output logic        oe_n
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_DATA,
    LOCKOUT
  } state_t;

  typedef enum logic [2:0] {
    ACC_NONE,
    ACC_WA,
    ACC_WD,
    ACC_RA,
    ACC_RD
  } acc_t;

  state_t      state, state_next;
  acc_t        acc;

  logic [15:0] a_q;
  logic        iorq_n_q;
  logic        rd_n_q;
  logic        wr_n_q;
  logic [7:0]  din_q;
  logic [7:0]  hold;

  logic        hold_load;
  logic        commit_addr;
  logic        commit_data;

  // Register the CPU bus so decode and capture see one stable copy per cycle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would make ordering of blocks matter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q      <= '0;
      iorq_n_q <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      din_q    <= '0;
    end else begin
      a_q      <= a;
      iorq_n_q <= iorq_n;
      rd_n_q   <= rd_n;
      wr_n_q   <= wr_n;
      din_q    <= din;
    end
  end

  // Classify the registered bus cycle; full 16-bit port compare.
  // Write takes priority should both strobes ever be low together.
  // NOTE: every combinational output gets a default first so no path
  // leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    acc = ACC_NONE;
    if (!iorq_n_q) begin
      if (!wr_n_q) begin
        if (a_q == IOADDR)      acc = ACC_WA;
        else if (a_q == IODATA) acc = ACC_WD;
      end else if (!rd_n_q) begin
        if (a_q == IOADDR)      acc = ACC_RA;
        else if (a_q == IODATA) acc = ACC_RD;
      end
    end
  end

  // State register; reset parks in LOCKOUT so an access already on the bus
  // at reset release is ignored until the bus goes idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= LOCKOUT;
    else        state <= state_next;
  end

  // Next-state logic plus the trailing-edge commit and capture controls.
  always_comb begin
    state_next  = state;
    hold_load   = 1'b0;
    commit_addr = 1'b0;
    commit_data = 1'b0;
    unique case (state)
      LOCKOUT: begin
        // Raw strobe: one genuinely idle bus cycle releases the lockout.
        if (iorq_n) state_next = IDLE;
      end
      IDLE: begin
        unique case (acc)
          ACC_WA: begin state_next = WR_ADDR; hold_load = 1'b1; end
          ACC_WD: begin state_next = WR_DATA; hold_load = 1'b1; end
          ACC_RA:       state_next = RD_ADDR;
          ACC_RD:       state_next = RD_DATA;
          default:      state_next = IDLE;
        endcase
      end
      WR_ADDR: begin
        if (acc == ACC_WA) hold_load = 1'b1;
        else begin
          state_next  = IDLE;
          commit_addr = 1'b1;
        end
      end
      WR_DATA: begin
        if (acc == ACC_WD) hold_load = 1'b1;
        else begin
          state_next  = IDLE;
          commit_data = 1'b1;
        end
      end
      RD_ADDR: begin
        if (acc != ACC_RA) state_next = IDLE;
      end
      RD_DATA: begin
        if (acc != ACC_RD) state_next = IDLE;
      end
      default: state_next = LOCKOUT;
    endcase
  end

  // Holding register and committed outputs; wdata keeps its value between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold        <= '0;
      zxuno_addr  <= '0;
      zxuno_regwr <= 1'b0;
      zxuno_wdata <= '0;
    end else begin
      zxuno_regwr <= commit_data;
      if (hold_load)   hold        <= din_q;
      if (commit_addr) zxuno_addr  <= hold;
      if (commit_data) zxuno_wdata <= hold;
    end
  end

  // Read side: both are decoded straight from the state register, so they
  // are registered levels and mutually exclusive by construction.
  assign zxuno_regrd = (state == RD_DATA);
  assign oe_n        = (state != RD_ADDR);
  assign dout        = zxuno_addr;

endmodule

// File: tb/tb_zxuno_regbus_ctrl.sv
// Scoreboard bench for zxuno_regbus_ctrl: stimulus pushes expected output
// events, a negedge monitor pops and compares whatever the DUT presents.
module tb_zxuno_regbus_ctrl;

  typedef enum logic [1:0] {EV_WR, EV_RDD, EV_RDA} ev_kind_t;
  typedef struct {
    ev_kind_t   kind;
    logic [7:0] data;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] a = 16'h0000;
  logic        iorq_n = 1'b1;
  logic        rd_n = 1'b1;
  logic        wr_n = 1'b1;
  logic [7:0]  din = 8'h00;
  logic [7:0]  zxuno_addr;
  logic        zxuno_regrd;
  logic        zxuno_regwr;
  logic [7:0]  zxuno_wdata;
  logic [7:0]  dout;
  logic        oe_n;

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_pass   = 0;

  zxuno_regbus_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .a           (a),
    .iorq_n      (iorq_n),
    .rd_n        (rd_n),
    .wr_n        (wr_n),
    .din         (din),
    .zxuno_addr  (zxuno_addr),
    .zxuno_regrd (zxuno_regrd),
    .zxuno_regwr (zxuno_regwr),
    .zxuno_wdata (zxuno_wdata),
    .dout        (dout),
    .oe_n        (oe_n)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  task automatic push(input ev_kind_t k, input logic [7:0] d, input int n);
    ev_t e;
    e.kind = k;
    e.data = d;
    for (int i = 0; i < n; i++) exp_q.push_back(e);
  endtask

  task automatic sb_compare(input ev_kind_t k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_event: got kind %0d data %h expected none (t=%0t)", k, d, $time);
    end else begin
      e = exp_q.pop_front();
      check("sb_kind", 16'(k), 16'(e.kind));
      check("sb_data", 16'(d), 16'(e.data));
    end
  endtask

  // Monitor: every cycle an output is active it must match the next expected event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (zxuno_regwr) sb_compare(EV_WR, zxuno_wdata);
      if (zxuno_regrd) sb_compare(EV_RDD, 8'h00);
      if (!oe_n)       sb_compare(EV_RDA, dout);
      if (zxuno_regrd || !oe_n)
        check("rd_oe_exclusive", 16'(zxuno_regrd & ~oe_n), 16'h0000);
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bus_idle();
    iorq_n = 1'b1;
    rd_n   = 1'b1;
    wr_n   = 1'b1;
  endtask

  // Write access held n cycles; din = d_first except d_last in the last cycle.
  task automatic cpu_write(input logic [15:0] port, input logic [7:0] d_first,
                           input logic [7:0] d_last, input int n);
    a      = port;
    iorq_n = 1'b0;
    wr_n   = 1'b0;
    for (int i = 0; i < n; i++) begin
      din = (i == n - 1) ? d_last : d_first;
      tick(1);
    end
    bus_idle();
  endtask

  task automatic cpu_read(input logic [15:0] port, input int n);
    a      = port;
    iorq_n = 1'b0;
    rd_n   = 1'b0;
    tick(n);
    bus_idle();
  endtask

  task automatic drain(input string name);
    tick(6);
    check(name, 16'(exp_q.size()), 16'h0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t expected below 200000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset values.
    tick(2);
    check("rst_addr",  16'(zxuno_addr),  16'h0000);
    check("rst_wdata", 16'(zxuno_wdata), 16'h0000);
    check("rst_dout",  16'(dout),        16'h0000);
    check("rst_regwr", 16'(zxuno_regwr), 16'h0000);
    check("rst_regrd", 16'(zxuno_regrd), 16'h0000);
    check("rst_oe_n",  16'(oe_n),        16'h0001);
    rst_n = 1'b1;
    tick(3);

    // IOADDR write of 0E for 3 cycles: select changes, no strobe.
    cpu_write(16'hFC3B, 8'h0E, 8'h0E, 3);
    check("wa_addr_not_yet", 16'(zxuno_addr), 16'h0000);
    tick(2);
    check("wa_addr_new", 16'(zxuno_addr), 16'h000E);
    drain("wa_drain");

    // IODATA write, din becomes A5 only in the last of 4 cycles.
    push(EV_WR, 8'hA5, 1);
    cpu_write(16'hFD3B, 8'h3C, 8'hA5, 4);
    drain("wd_drain");
    check("wd_addr_kept", 16'(zxuno_addr), 16'h000E);
    check("wd_wdata_held", 16'(zxuno_wdata), 16'h00A5);

    // Single-cycle IODATA write still strobes once.
    push(EV_WR, 8'h71, 1);
    cpu_write(16'hFD3B, 8'h71, 8'h71, 1);
    drain("wd1_drain");

    // IODATA read for 3 cycles: regrd for 3 cycles, lagging by one.
    push(EV_RDD, 8'h00, 3);
    a = 16'hFD3B; iorq_n = 1'b0; rd_n = 1'b0;
    tick(1);
    check("rd_lag_first", 16'(zxuno_regrd), 16'h0000);
    tick(2);
    bus_idle();
    check("rd_high_after", 16'(zxuno_regrd), 16'h0001);
    tick(2);
    check("rd_low_end", 16'(zxuno_regrd), 16'h0000);
    drain("rd_drain");

    // IOADDR read for 2 cycles returns the selected register.
    push(EV_RDA, 8'h0E, 2);
    cpu_read(16'hFC3B, 2);
    drain("ra_drain");

    // Near-miss ports: nothing happens.
    cpu_write(16'hFC3A, 8'h55, 8'h55, 3);
    tick(1);
    cpu_write(16'hFE3B, 8'h66, 8'h66, 3);
    drain("nomatch_drain");
    check("nomatch_addr",  16'(zxuno_addr),  16'h000E);
    check("nomatch_wdata", 16'(zxuno_wdata), 16'h0071);

    // Reset pulsed mid IODATA write, released with iorq_n still low.
    a = 16'hFD3B; iorq_n = 1'b0; wr_n = 1'b0; din = 8'hC3;
    tick(2);
    rst_n = 1'b0;
    #1;
    check("midrst_addr",  16'(zxuno_addr),  16'h0000);
    check("midrst_regwr", 16'(zxuno_regwr), 16'h0000);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    bus_idle();
    drain("midrst_drain");
    check("midrst_addr_after",  16'(zxuno_addr),  16'h0000);
    check("midrst_wdata_after", 16'(zxuno_wdata), 16'h0000);

    // Next full write strobes normally.
    push(EV_WR, 8'h5A, 1);
    cpu_write(16'hFD3B, 8'h5A, 8'h5A, 2);
    drain("post_rst_drain");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/zxuno_regbus_ctrl.md
ZXUNO_REGBUS_CTRL -- requirements
Module: zxuno_regbus_ctrl

Interface
REQ-001 SHALL have parameter IOADDR, default 16'hFC3B, meaning the Z80 I/O port that selects the register number.
REQ-002 SHALL have parameter IODATA, default 16'hFD3B, meaning the Z80 I/O port that reads or writes the selected register.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port a, input, 16 bits: the Z80 address bus.
REQ-006 SHALL have ports iorq_n, rd_n, wr_n, each input, 1 bit: the Z80 bus strobes, active-low and synchronous to clk.
REQ-007 SHALL have port din, input, 8 bits: the Z80 data bus carrying CPU write data.
REQ-008 SHALL have port zxuno_addr, output, 8 bits: the currently selected register number.
REQ-009 SHALL have port zxuno_regrd, output, 1 bit: a level that is high during a read of IODATA.
REQ-010 SHALL have port zxuno_regwr, output, 1 bit: a one-cycle write strobe for IODATA.
REQ-011 SHALL have port zxuno_wdata, output, 8 bits: the write data, valid while zxuno_regwr is high.
REQ-012 SHALL have port dout, output, 8 bits: the IOADDR readback value, i.e. zxuno_addr.
REQ-013 SHALL have port oe_n, output, 1 bit: low while dout drives the CPU bus.

Function
REQ-014 SHALL decode access types from the registered bus signals each cycle:
- WA: iorq_n=0, wr_n=0, a=IOADDR
- WD: iorq_n=0, wr_n=0, a=IODATA
- RA: iorq_n=0, rd_n=0, a=IOADDR
- RD: iorq_n=0, rd_n=0, a=IODATA
- full 16-bit compare
- any other port: no access.
REQ-015 SHALL implement states IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_DATA and LOCKOUT.
REQ-016 In IDLE, the FSM SHALL go to WR_ADDR on WA, WR_DATA on WD, RD_ADDR on RA, RD_DATA on RD, and otherwise stay in IDLE.
REQ-017 In each WR_* or RD_* state, the FSM SHALL stay while its access remains decoded, and return to IDLE on the first cycle it is not decoded.
REQ-018 In WR_ADDR and WR_DATA, SHALL capture din into a holding register on every cycle, so the last asserted cycle's data is kept.
REQ-019 On WR_ADDR -> IDLE, SHALL load zxuno_addr from the holding register; the new value is visible on the next cycle.
REQ-020 On WR_DATA -> IDLE, SHALL pulse zxuno_regwr high for exactly one cycle with zxuno_wdata equal to the holding register; zxuno_addr SHALL be unchanged.
REQ-021 SHALL produce at most one zxuno_regwr pulse per CPU write access, whatever the access length.
REQ-022 zxuno_regrd SHALL be high from the cycle after RD is first decoded until the cycle after RD ends, i.e. a registered level.
REQ-023 oe_n SHALL be low and dout SHALL equal zxuno_addr in every cycle the FSM is in RD_ADDR; otherwise oe_n=1.
REQ-024 zxuno_regrd and oe_n SHALL never both be active in the same cycle.
REQ-025 A change of port address or strobe type mid-access SHALL end the current access (including its trailing-edge commit) and pass through IDLE before a new access is recognised.
REQ-026 zxuno_wdata SHALL hold its last value between strobes.
REQ-027 A single-cycle access SHALL be honoured: one cycle in WR_DATA still yields one strobe.

Reset
REQ-028 While rst_n=0, outputs SHALL be: zxuno_addr=8'h00, zxuno_wdata=8'h00, dout=8'h00, zxuno_regwr=0, zxuno_regrd=0, oe_n=1; the holding register SHALL be 8'h00 and the state LOCKOUT.
REQ-029 LOCKOUT SHALL ignore all accesses and go to IDLE only after one cycle with iorq_n=1, so an access in progress at reset release produces no commit or strobe.
REQ-030 Assertion of rst_n mid-access SHALL discard the pending commit immediately, with no zxuno_regwr pulse.

Verification
REQ-031 Bench SHALL cover a FC3B write: write 8'h0E for 3 cycles -> zxuno_addr=8'h0E one cycle after the access ends, and zxuno_regwr never pulses.
REQ-032 Bench SHALL cover a FD3B write: write 8'hA5 held for 4 cycles with din changing to 8'hA5 in the last cycle -> exactly one zxuno_regwr pulse with zxuno_wdata=8'hA5 after the access ends.
REQ-033 Bench SHALL cover a FD3B read: read held 3 cycles -> zxuno_regrd high for 3 cycles lagging by one, oe_n stays 1, no regwr.
REQ-034 Bench SHALL cover a FC3B read after selecting 8'h0E: read held 2 cycles -> oe_n low 2 cycles with dout=8'h0E.
REQ-035 Bench SHALL cover reset mid-access: rst_n pulsed low during a FD3B write, then released with iorq_n still 0 -> no zxuno_regwr, zxuno_addr=8'h00, and the next full write strobes normally.
REQ-036 Bench SHALL cover non-matching ports: writes to 16'hFC3A and 16'hFE3B -> no state change and no strobes.
